intr_router: RTL and testbench

INTR_ROUTER -- requirements
Module: intr_router

---
 rtl/intr_router.sv | 207 ++++++++++++++++++++
 tb/tb_intr_router.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/intr_router.sv
// +----------------------------------------------------------------------+
// | intr_router: level/edge interrupt router with per-target enable and  |
// | claim registers on a register-interface bus.   Rev 1.0               |
// +----------------------------------------------------------------------+
`default_nettype none

package core_v_mcu_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module intr_router #(
  parameter int unsigned NumSrc = 16,
  parameter int unsigned NumTgt = 2,
  parameter type reg_req_t = core_v_mcu_pkg::reg_req_t,
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  reg_req_t          reg_req_i,
  output reg_rsp_t          reg_rsp_o,
  input  logic [NumSrc-1:0] intr_i,
  output logic [NumTgt-1:0] irq_o
);

  localparam logic [7:0] C_OFF_PENDING = 8'h00;
  localparam logic [7:0] C_OFF_MODE    = 8'h04;
  localparam logic [7:0] C_OFF_SET     = 8'h08;

  logic [NumSrc-1:0] r_intr_q;
  logic [NumSrc-1:0] r_pending;
  logic [NumSrc-1:0] r_mode;
  logic [NumSrc-1:0] r_enable [NumTgt];
  logic [NumTgt-1:0] r_irq;

  logic              w_valid;
  logic [7:0]        w_off;
  logic [31:0]       w_bmask;
  logic [31:0]       w_wdata32;
  logic [NumSrc-1:0] w_bm;
  logic [NumSrc-1:0] w_wd;
  logic              w_hit;
  logic              w_bad;
  logic              w_err;
  logic              w_act;
  logic [31:0]       w_rdata;
  logic              w_pend_sel;
  logic              w_mode_sel;
  logic              w_set_sel;
  logic [NumTgt-1:0] w_en_sel;
  logic [NumTgt-1:0] w_claim_sel;
  logic [5:0]        w_claim_idx [NumTgt];
  logic [NumSrc-1:0] w_claim_oh  [NumTgt];
  logic [NumSrc-1:0] w_cand      [NumTgt];
  logic [NumSrc-1:0] w_set;
  logic [NumSrc-1:0] w_clr;
  logic              w_unused;

  function automatic logic [31:0] ext(input logic [NumSrc-1:0] v);
    logic [31:0] r;
    r = '0;
    r[NumSrc-1:0] = v;
    return r;
  endfunction

  // Accesses are ignored while in reset so a dropped transaction has no side effect.
  assign w_valid = reg_req_i.valid & rst_ni;
  assign w_off   = reg_req_i.addr[7:0];

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_bmask[8*b +: 8] = {8{reg_req_i.wstrb[b]}};
    end
  end

  assign w_wdata32 = reg_req_i.wdata & w_bmask;
  assign w_bm      = w_bmask[NumSrc-1:0];
  assign w_wd      = w_wdata32[NumSrc-1:0];

  // Lowest pending-and-enabled source per target; index reported as i+1.
  always_comb begin
    for (int t = 0; t < NumTgt; t++) begin
      w_cand[t]      = r_pending & r_enable[t];
      w_claim_idx[t] = '0;
      w_claim_oh[t]  = '0;
      for (int i = NumSrc - 1; i >= 0; i--) begin
        if (w_cand[t][i]) begin
          w_claim_idx[t]   = 6'(i + 1);
          w_claim_oh[t]    = '0;
          w_claim_oh[t][i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_hit       = 1'b0;
    w_bad       = 1'b0;
    w_rdata     = '0;
    w_pend_sel  = 1'b0;
    w_mode_sel  = 1'b0;
    w_set_sel   = 1'b0;
    w_en_sel    = '0;
    w_claim_sel = '0;
    case (w_off)
      C_OFF_PENDING: begin
        w_hit      = 1'b1;
        w_pend_sel = 1'b1;
        w_rdata    = ext(r_pending);
      end
      C_OFF_MODE: begin
        w_hit      = 1'b1;
        w_mode_sel = 1'b1;
        w_rdata    = ext(r_mode);
      end
      C_OFF_SET: begin
        w_hit     = 1'b1;
        w_set_sel = 1'b1;
        w_bad     = ~reg_req_i.write;
      end
      default: ;
    endcase
    for (int t = 0; t < NumTgt; t++) begin
      if (w_off == 8'(16 + 8 * t)) begin
        w_hit       = 1'b1;
        w_en_sel[t] = 1'b1;
        w_rdata     = ext(r_enable[t]);
      end
      if (w_off == 8'(20 + 8 * t)) begin
        w_hit          = 1'b1;
        w_claim_sel[t] = 1'b1;
        w_bad          = reg_req_i.write;
        w_rdata        = 32'(w_claim_idx[t]);
      end
    end
  end

  assign w_err = w_valid & (~w_hit | w_bad);
  assign w_act = w_valid & ~w_err;

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = 1'b1;
    reg_rsp_o.error = w_err;
    if (w_act && !reg_req_i.write) begin
      reg_rsp_o.rdata = w_rdata;
    end
  end

  // Set sources are OR-ed in after the clear so set wins on a collision.
  always_comb begin
    w_set = (intr_i & ~r_intr_q & r_mode) | (intr_i & ~r_mode);
    w_clr = '0;
    if (w_act && reg_req_i.write && w_set_sel) begin
      w_set = w_set | w_wd;
    end
    if (w_act && reg_req_i.write && w_pend_sel) begin
      w_clr = w_wd;
    end
    for (int t = 0; t < NumTgt; t++) begin
      if (w_act && !reg_req_i.write && w_claim_sel[t]) begin
        w_clr = w_clr | w_claim_oh[t];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_intr_q  <= '0;
      r_pending <= '0;
      r_mode    <= '0;
      r_irq     <= '0;
      for (int t = 0; t < NumTgt; t++) begin
        r_enable[t] <= '0;
      end
    end else begin
      r_intr_q  <= intr_i;
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_act && reg_req_i.write && w_mode_sel) begin
        r_mode <= (r_mode & ~w_bm) | w_wd;
      end
      for (int t = 0; t < NumTgt; t++) begin
        r_irq[t] <= |(r_pending & r_enable[t]);
        if (w_act && reg_req_i.write && w_en_sel[t]) begin
          r_enable[t] <= (r_enable[t] & ~w_bm) | w_wd;
        end
      end
    end
  end

  assign irq_o    = r_irq;
  assign w_unused = ^{reg_req_i.addr[31:8], w_wdata32, w_bmask};

endmodule

`default_nettype wire

// File: tb/tb_intr_router.sv
// Directed self-checking bench for intr_router (NumSrc=16, NumTgt=2).
`default_nettype none

module tb_intr_router;

  logic                      clk;
  logic                      rst_ni;
  core_v_mcu_pkg::reg_req_t  req;
  core_v_mcu_pkg::reg_rsp_t  rsp;
  logic [15:0]               intr;
  logic [1:0]                irq;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        er;
  logic        rdy;

  intr_router #(.NumSrc(16), .NumTgt(2)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .reg_req_i (req),
    .reg_rsp_o (rsp),
    .intr_i    (intr),
    .irq_o     (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus access: drive, sample the combinational response, then let one edge take it.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata,
                        output logic err, output logic ready);
    req.valid = 1'b1;
    req.write = wr;
    req.addr  = addr;
    req.wdata = wdata;
    req.wstrb = strb;
    #1;
    rdata = rsp.rdata;
    err   = rsp.error;
    ready = rsp.ready;
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    req.write = 1'b0;
  endtask

  task automatic wr32(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    logic        r;
    access(1'b1, addr, data, 4'hF, d, e, r);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    logic        r;
    access(1'b0, addr, 32'h0, 4'hF, d, e, r);
    chk(tag, d, exp);
  endtask

  initial begin
    rst_ni = 1'b0;
    req    = '0;
    intr   = '0;
    tick();
    tick();

    // Response during reset: read MODE, must give rdata 0, error 0, ready 1.
    req.valid = 1'b1;
    req.addr  = 32'h04;
    #1;
    chk("rst_rdata", rsp.rdata, 32'h0);
    chk("rst_error", {31'h0, rsp.error}, 32'h0);
    chk("rst_ready", {31'h0, rsp.ready}, 32'h1);
    chk("rst_irq", {30'h0, irq}, 32'h0);
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    rst_ni    = 1'b1;
    tick();
    rd_chk("pend_after_rst", 32'h00, 32'h0);

    // Level source 0 routed to target 0: pending at N+1, irq at N+2.
    wr32(32'h10, 32'h1);
    intr[0] = 1'b1;
    tick();
    chk("t26_irq_n1", {30'h0, irq}, 32'h0);
    rd_chk("t26_pend_n1", 32'h00, 32'h1);
    chk("t26_irq_n2", {30'h0, irq}, 32'h1);
    intr[0] = 1'b0;
    wr32(32'h00, 32'h1);
    wr32(32'h10, 32'h0);
    tick();

    // Edge source 3 on target 1 with a one-cycle pulse, then claim.
    wr32(32'h04, 32'h8);
    wr32(32'h18, 32'h8);
    intr[3] = 1'b1;
    tick();
    intr[3] = 1'b0;
    tick();
    rd_chk("t27_pend_held", 32'h00, 32'h8);
    chk("t27_irq_up", {30'h0, irq}, 32'h2);
    rd_chk("t27_claim1", 32'h1C, 32'h4);
    chk("t27_irq_1after", {30'h0, irq}, 32'h2);
    rd_chk("t27_pend_clr", 32'h00, 32'h0);
    chk("t27_irq_2after", {30'h0, irq}, 32'h0);

    // Edge source held high does not retrigger after a clear.
    intr[3] = 1'b1;
    tick();
    rd_chk("edge_hold_pend", 32'h00, 32'h8);
    wr32(32'h00, 32'h8);
    tick();
    rd_chk("edge_no_retrig", 32'h00, 32'h0);
    intr[3] = 1'b0;
    tick();

    // Level source 5 re-pends while high; clear sticks once it drops.
    intr[5] = 1'b1;
    tick();
    rd_chk("t28_pend", 32'h00, 32'h20);
    wr32(32'h00, 32'h20);
    rd_chk("t28_repend", 32'h00, 32'h20);
    intr[5] = 1'b0;
    wr32(32'h00, 32'h20);
    rd_chk("t28_cleared", 32'h00, 32'h0);

    // Software set and priority claim order.
    wr32(32'h10, 32'h0C);
    wr32(32'h08, 32'h0C);
    rd_chk("t29_claim_a", 32'h14, 32'h3);
    rd_chk("t29_claim_b", 32'h14, 32'h4);
    rd_chk("t29_claim_c", 32'h14, 32'h0);

    // Error responses with no state change.
    access(1'b0, 32'hF0, 32'h0, 4'hF, rd, er, rdy);
    chk("t30_unmapped_err", {31'h0, er}, 32'h1);
    chk("t30_unmapped_rdy", {31'h0, rdy}, 32'h1);
    access(1'b1, 32'h14, 32'hFFFF, 4'hF, rd, er, rdy);
    chk("t30_wr_claim_err", {31'h0, er}, 32'h1);
    access(1'b0, 32'h08, 32'h0, 4'hF, rd, er, rdy);
    chk("t30_rd_set_err", {31'h0, er}, 32'h1);
    chk("t30_rd_set_data", rd, 32'h0);
    access(1'b1, 32'h20, 32'hFFFF, 4'hF, rd, er, rdy);
    chk("t30_tgt2_err", {31'h0, er}, 32'h1);
    rd_chk("t30_mode_keep", 32'h04, 32'h8);
    rd_chk("t30_en0_keep", 32'h10, 32'h0C);
    rd_chk("t30_en1_keep", 32'h18, 32'h8);
    rd_chk("t30_pend_keep", 32'h00, 32'h0);

    // Byte strobes and unimplemented upper bits.
    access(1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0010, rd, er, rdy);
    rd_chk("strb_mode", 32'h04, 32'h0000_FF08);
    wr32(32'h04, 32'h4);
    rd_chk("mode_rewrite", 32'h04, 32'h4);

    // Edge event and PENDING clear on the same bit: set wins.
    intr[2] = 1'b1;
    wr32(32'h00, 32'h4);
    rd_chk("t31_set_wins", 32'h00, 32'h4);
    chk("t31_irq_pre", {30'h0, irq}, 32'h1);

    // Asynchronous reset mid-cycle.
    #2;
    rst_ni    = 1'b0;
    req.valid = 1'b1;
    req.addr  = 32'h00;
    #1;
    chk("t31_async_irq", {30'h0, irq}, 32'h0);
    chk("t31_async_rdata", rsp.rdata, 32'h0);
    chk("t31_async_err", {31'h0, rsp.error}, 32'h0);
    chk("t31_async_rdy", {31'h0, rsp.ready}, 32'h1);
    @(posedge clk);
    #1;
    req.valid = 1'b0;
    rst_ni    = 1'b1;
    tick();
    rd_chk("post_rst_level", 32'h00, 32'h4);
    rd_chk("post_rst_mode", 32'h04, 32'h0);
    rd_chk("post_rst_en0", 32'h10, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
